input_loader: RTL and testbench
===============================

INPUT_LOADER -- requirements
Module: input_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the signed data word width.
REQ-002 The block SHALL have parameter M, default 3, giving the number of matrix rows.
REQ-003 The block SHALL have parameter N, default 3, giving the number of matrix columns and the vector length.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port input_data, input, WIDTH bits, signed: the stream word.
REQ-007 The block SHALL have port input_valid, input, 1 bit: input_data is valid this cycle.
REQ-008 The block SHALL have port input_ready, output, 1 bit, registered: the loader accepts a word this cycle.
REQ-009 The block SHALL have port m_addr, output, $clog2(M*N) bits: matrix memory write address.
REQ-010 The block SHALL have port m_data, output, WIDTH bits: matrix memory write data.
REQ-011 The block SHALL have port m_wr_en, output, 1 bit: matrix memory write strobe.
REQ-012 The block SHALL have port v_addr, output, $clog2(N) bits: vector memory write address.
REQ-013 The block SHALL have port v_data, output, WIDTH bits: vector memory write data.
REQ-014 The block SHALL have port v_wr_en, output, 1 bit: vector memory write strobe.
REQ-015 The block SHALL have port load_done, output, 1 bit: both memories hold a complete frame.
REQ-016 The block SHALL have port compute_done, input, 1 bit, single-cycle pulse: the consumer has finished with the frame.

Function
REQ-017 The block SHALL define a handshake as input_valid and input_ready both high at a rising edge; no word is consumed otherwise.
REQ-018 The state machine SHALL have states LOAD_M, LOAD_V and WAIT.
- A frame is M*N matrix words, row-major (addr = row*N + col), followed by N vector words.
REQ-019 In LOAD_M, each handshake SHALL write input_data to m_addr = matrix counter, then increment the counter; the handshake at count M*N-1 SHALL clear the counter and move the FSM to LOAD_V.
REQ-020 In LOAD_V, each handshake SHALL write input_data to v_addr = vector counter; the handshake at count N-1 SHALL clear the counter, move the FSM to WAIT and deassert input_ready at that same edge.
REQ-021 Write latency SHALL be exactly 1 cycle: m_addr/m_data/m_wr_en (or v_*) are registered at the handshake edge and valid for one cycle; the strobes are never both high.
REQ-022 load_done SHALL be high exactly while the FSM is in WAIT, rising the cycle after the last vector handshake.
REQ-023 In WAIT, compute_done SHALL move the FSM to LOAD_M and set input_ready at the same edge.
REQ-024 compute_done outside WAIT SHALL be ignored.
REQ-025 input_valid while input_ready is low SHALL be ignored, with no write and no counter change.
REQ-026 Bubbles (input_valid low) SHALL hold all counters and state; back-to-back handshakes SHALL sustain one word per cycle across the LOAD_M->LOAD_V boundary.

Reset
REQ-027 While reset_n is low: the FSM SHALL be in LOAD_M; both counters SHALL be 0; input_ready, m_wr_en, v_wr_en and load_done SHALL be 0; m_addr, m_data, v_addr and v_data SHALL be 0.
REQ-028 input_ready SHALL rise at the first rising edge after reset_n deasserts.
REQ-029 Reset mid-frame SHALL discard the partial frame, and the next frame SHALL start at matrix address 0.

Configuration
REQ-030 When MATRIX_REUSE_EN is defined, the block SHALL add input port input_new_matrix (1 bit), sampled only with the first handshake of a frame:
- if high, the frame loads matrix then vector as normal;
- if low, that first word is written to v_addr 0 and the frame is vector-only, with N words and the FSM going directly to LOAD_V.
REQ-031 When MATRIX_REUSE_EN is undefined, the port SHALL be absent and every frame SHALL include the matrix.

Verification
REQ-032 M=N=3, continuous valid, words 1..12 -> m writes addr0..8 data 1..9, v writes addr0..2 data 10..12, load_done high from cycle 13, input_ready low.
REQ-033 Same stream with input_valid toggling 1,0 -> identical writes, one every two cycles, and no duplicate writes.
REQ-034 compute_done pulsed during LOAD_V, then again in WAIT -> first pulse ignored; second returns to LOAD_M, and the next word goes to m_addr 0.
REQ-035 reset_n low after 5 matrix words, then a full frame of 101..112 -> m addr0..8 = 101..109, v addr0..2 = 110..112.
REQ-036 input_valid held high during WAIT with data 77 -> no write strobes, and 77 is accepted only after compute_done.
REQ-037 With MATRIX_REUSE_EN, second frame with input_new_matrix=0 and words 20,21,22 -> only v writes 20..22, matrix untouched, load_done after the 3rd handshake.

Source files
------------

// File: rtl/input_loader.sv
// Stream loader: splits an input word stream into an M*N matrix memory and an N-word vector memory.
// Optional MATRIX_REUSE_EN adds input_new_matrix so that a frame can carry a vector only.
module input_loader #(
    parameter  int WIDTH = 12,
    parameter  int M     = 3,
    parameter  int N     = 3,
    localparam int MAW   = (M * N > 1) ? $clog2(M * N) : 1,
    localparam int VAW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] input_data,
    input  logic                    input_valid,
    output logic                    input_ready,
    output logic [MAW-1:0]          m_addr,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_wr_en,
    output logic [VAW-1:0]          v_addr,
    output logic [WIDTH-1:0]        v_data,
    output logic                    v_wr_en,
`ifdef MATRIX_REUSE_EN
    input  logic                    input_new_matrix,
`endif
    input  logic                    compute_done,
    output logic                    load_done
);

    typedef enum logic [1:0] {
        LOAD_M = 2'd0,
        LOAD_V = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_ready;
    logic [MAW-1:0]            r_m_cnt;
    logic [VAW-1:0]            r_v_cnt;
    logic                      r_m_wr;
    logic [MAW-1:0]            r_m_addr;
    logic signed [WIDTH-1:0]   r_m_data;
    logic                      r_v_wr;
    logic [VAW-1:0]            r_v_addr;
    logic signed [WIDTH-1:0]   r_v_data;

    logic                      w_hs;
    logic                      w_vec_only;
    logic                      w_m_last;
    logic                      w_v_last;
    logic                      w_m_wr;
    logic                      w_v_wr;
    logic [VAW-1:0]            w_v_addr;
    logic                      w_ready_next;

    assign w_hs     = input_valid & r_ready;
    assign w_m_last = (r_m_cnt == MAW'(M * N - 1));
    assign w_v_last = (r_v_cnt == VAW'(N - 1));

    // A vector-only frame is decided by the very first handshake of the frame.
`ifdef MATRIX_REUSE_EN
    assign w_vec_only = (r_state == LOAD_M) && (r_m_cnt == '0) && !input_new_matrix;
`else
    assign w_vec_only = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LOAD_M;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD_M: begin
                if (w_hs) begin
                    if (w_vec_only) begin
                        w_state_next = (N == 1) ? WAIT : LOAD_V;
                    end else if (w_m_last) begin
                        w_state_next = LOAD_V;
                    end
                end
            end
            LOAD_V: begin
                if (w_hs && w_v_last) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (compute_done) begin
                    w_state_next = LOAD_M;
                end
            end
            default: w_state_next = LOAD_M;
        endcase
    end

    always_comb begin
        w_m_wr       = w_hs && (r_state == LOAD_M) && !w_vec_only;
        w_v_wr       = w_hs && ((r_state == LOAD_V) || w_vec_only);
        w_v_addr     = w_vec_only ? '0 : r_v_cnt;
        w_ready_next = (w_state_next != WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= 1'b0;
            r_m_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_ready <= w_ready_next;
            if (w_m_wr) begin
                r_m_cnt <= w_m_last ? '0 : r_m_cnt + MAW'(1);
            end
            if (w_v_wr) begin
                if (w_vec_only) begin
                    r_v_cnt <= (N == 1) ? '0 : VAW'(1);
                end else begin
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + VAW'(1);
                end
            end
        end
    end

    // Write ports: one-cycle strobes, address/data held between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_wr   <= 1'b0;
            r_m_addr <= '0;
            r_m_data <= '0;
            r_v_wr   <= 1'b0;
            r_v_addr <= '0;
            r_v_data <= '0;
        end else begin
            r_m_wr <= w_m_wr;
            r_v_wr <= w_v_wr;
            if (w_m_wr) begin
                r_m_addr <= r_m_cnt;
                r_m_data <= input_data;
            end
            if (w_v_wr) begin
                r_v_addr <= w_v_addr;
                r_v_data <= input_data;
            end
        end
    end

    assign input_ready = r_ready;
    assign m_wr_en     = r_m_wr;
    assign m_addr      = r_m_addr;
    assign m_data      = r_m_data;
    assign v_wr_en     = r_v_wr;
    assign v_addr      = r_v_addr;
    assign v_data      = r_v_data;
    assign load_done   = (r_state == WAIT);

endmodule

// File: tb/tb_input_loader.sv
// Bench for input_loader: directed frames plus random traffic against a frame-position reference model.
// Covers the MATRIX_REUSE_EN build when that macro is defined.
module tb_input_loader;
    localparam int WIDTH = 12;
    localparam int M     = 3;
    localparam int N     = 3;
    localparam int MN    = M * N;
`ifdef MATRIX_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic signed [WIDTH-1:0] input_data = '0;
    logic                    input_valid = 1'b0;
    logic                    input_ready;
    logic [3:0]              m_addr;
    logic [WIDTH-1:0]        m_data;
    logic                    m_wr_en;
    logic [1:0]              v_addr;
    logic [WIDTH-1:0]        v_data;
    logic                    v_wr_en;
    logic                    compute_done = 1'b0;
    logic                    load_done;
`ifdef MATRIX_REUSE_EN
    logic                    input_new_matrix = 1'b1;
`endif

    input_loader #(.WIDTH(WIDTH), .M(M), .N(N)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .input_data       (input_data),
        .input_valid      (input_valid),
        .input_ready      (input_ready),
        .m_addr           (m_addr),
        .m_data           (m_data),
        .m_wr_en          (m_wr_en),
        .v_addr           (v_addr),
        .v_data           (v_data),
        .v_wr_en          (v_wr_en),
`ifdef MATRIX_REUSE_EN
        .input_new_matrix (input_new_matrix),
`endif
        .compute_done     (compute_done),
        .load_done        (load_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: position within the frame, waiting flag, expected memory images.
    int mdl_pos   = 0;
    bit mdl_wait  = 1'b0;
    bit mdl_ready = 1'b0;
    int exp_m [MN];
    int exp_v [N];
    int shd_m [MN];
    int shd_v [N];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit vld, input int data, input bit cd, input bit newm);
        bit hs;
        bit e_mwr;
        bit e_vwr;
        int e_addr;
        int e_data;
        @(negedge clk);
        input_valid  = vld;
        input_data   = data[WIDTH-1:0];
        compute_done = cd;
`ifdef MATRIX_REUSE_EN
        input_new_matrix = newm;
`endif
        hs     = vld && mdl_ready;
        e_mwr  = 1'b0;
        e_vwr  = 1'b0;
        e_addr = 0;
        e_data = data & ((1 << WIDTH) - 1);
        if (mdl_wait) begin
            if (cd) mdl_wait = 1'b0;
        end else if (hs) begin
            if (REUSE && mdl_pos == 0 && !newm) mdl_pos = MN;
            if (mdl_pos < MN) begin
                e_mwr = 1'b1;
                e_addr = mdl_pos;
                exp_m[e_addr] = e_data;
            end else begin
                e_vwr = 1'b1;
                e_addr = mdl_pos - MN;
                exp_v[e_addr] = e_data;
            end
            mdl_pos++;
            if (mdl_pos == MN + N) begin
                mdl_pos  = 0;
                mdl_wait = 1'b1;
            end
        end
        mdl_ready = !mdl_wait;
        @(posedge clk);
        #1;
        check_val("m_wr_en", m_wr_en, e_mwr);
        check_val("v_wr_en", v_wr_en, e_vwr);
        check_val("load_done", load_done, mdl_wait);
        check_val("input_ready", input_ready, mdl_ready);
        if (e_mwr) begin
            check_val("m_addr", m_addr, e_addr);
            check_val("m_data", m_data, e_data);
        end
        if (e_vwr) begin
            check_val("v_addr", v_addr, e_addr);
            check_val("v_data", v_data, e_data);
        end
        if (m_wr_en && m_addr < MN) shd_m[m_addr] = m_data;
        if (v_wr_en && v_addr < N) shd_v[v_addr] = v_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        input_valid  = 1'b0;
        compute_done = 1'b0;
        #1;
        check_val("rst_ready", input_ready, 0);
        check_val("rst_m_wr", m_wr_en, 0);
        check_val("rst_v_wr", v_wr_en, 0);
        check_val("rst_load_done", load_done, 0);
        check_val("rst_m_addr", m_addr, 0);
        check_val("rst_m_data", m_data, 0);
        check_val("rst_v_addr", v_addr, 0);
        check_val("rst_v_data", v_data, 0);
        mdl_pos   = 0;
        mdl_wait  = 1'b0;
        mdl_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mdl_ready = 1'b1;
        check_val("ready_after_reset", input_ready, 1);
    endtask

    task automatic mem_check(input string tag);
        for (int i = 0; i < MN; i++) check_val({tag, "_mem_m"}, shd_m[i], exp_m[i]);
        for (int i = 0; i < N; i++) check_val({tag, "_mem_v"}, shd_v[i], exp_v[i]);
    endtask

    initial begin
        for (int i = 0; i < MN; i++) begin exp_m[i] = 0; shd_m[i] = 0; end
        for (int i = 0; i < N; i++) begin exp_v[i] = 0; shd_v[i] = 0; end

        do_reset();

        // Continuous frame 1..12
        for (int i = 1; i <= 12; i++) step(1'b1, i, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        check_val("frame1_done", load_done, 1);
        mem_check("frame1");
        step(1'b0, 0, 1'b1, 1'b1);

        // Alternating valid
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, i + 300, 1'b0, 1'b1);
            step(1'b0, 999, 1'b0, 1'b1);
        end
        mem_check("toggle");
        step(1'b0, 0, 1'b1, 1'b1);

        // compute_done in LOAD_V ignored, then honoured in WAIT
        for (int i = 0; i < MN; i++) step(1'b1, 30 + i, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, 39 + i, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b1, 50, 1'b0, 1'b1);

        // Valid held in WAIT with 77
        for (int i = 1; i < MN + N; i++) step(1'b1, 50 + i, 1'b0, 1'b1);
        repeat (3) step(1'b1, 77, 1'b0, 1'b1);
        step(1'b1, 77, 1'b1, 1'b1);
        step(1'b1, 77, 1'b0, 1'b1);
        check_val("word77_at_m0", shd_m[0], 77);
        mem_check("wait_hold");

        // Reset mid-frame, then 101..112
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, i, 1'b0, 1'b1);
        do_reset();
        for (int i = 101; i <= 112; i++) step(1'b1, i, 1'b0, 1'b1);
        mem_check("after_reset");
        check_val("m8_after_reset", shd_m[8], 109);
        step(1'b0, 0, 1'b1, 1'b1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1));
        end
        mem_check("random");

`ifdef MATRIX_REUSE_EN
        // Vector-only frame reuses the previous matrix
        do_reset();
        for (int i = 1; i <= 12; i++) step(1'b1, i, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 20; i <= 22; i++) step(1'b1, i, 1'b0, 1'b0);
        check_val("reuse_done", load_done, 1);
        check_val("reuse_m0_kept", shd_m[0], 1);
        check_val("reuse_v2", shd_v[2], 22);
        mem_check("reuse");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
